// File: rtl/simm_pkg.sv
// Shared definitions for the SIMM bus interface and controller: FSM states,
// 68030 SIZ encodings and the byte-lane bit ordering.
package simm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StBeatGap,
    StAck
  } state_e;

  typedef enum logic [1:0] {
    SizLong   = 2'b00,
    SizByte   = 2'b01,
    SizWord   = 2'b10,
    SizTriple = 2'b11
  } siz_e;

  localparam int unsigned NumLanes = 4;

  // Byte offset 0 (D31:24) lives in the MSB of byte_selects.
  function automatic logic [1:0] lane_bit(input logic [1:0] off);
    return 2'd3 - off;
  endfunction

  // Enable offsets a .. min(3, a + size - 1); SIZ=00 means four bytes.
  function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] a);
    logic [2:0] last;
    logic [3:0] mask;
    last = (siz == SizLong) ? 3'd3 : ({1'b0, a} + {1'b0, siz} - 3'd1);
    mask = '0;
    for (int unsigned off = 0; off < NumLanes; off++) begin
      if (off >= 32'(a) && off <= 32'(last)) mask[lane_bit(2'(off))] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous CPU strobes.
module sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] stage_q, stage_d;

  always_comb begin
    stage_d = {stage_q[0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stage_q <= {2{ResetVal}};
    else       stage_q <= stage_d;
  end

  assign q_o = stage_q[1];

endmodule

// File: rtl/simm_bus_interface.sv
// Bridges the asynchronous 68030 bus cycle (incl. cache burst fills) onto the
// synchronous cs/ds handshake of simm_controller.
module simm_bus_interface
  import simm_pkg::*;
#(
  parameter logic [31:0] DRAM_BASE      = 32'h0000_0000,
  parameter int unsigned DRAM_SIZE_LOG2 = 26,
  parameter int unsigned BANK_BIT       = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_as_n,
  input  logic        cpu_ds_n,
  input  logic        cpu_rn_w,
  input  logic [1:0]  cpu_siz,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_cbreq_n,
  output logic [1:0]  cpu_dsack_n,
  output logic        cpu_cback_n,
  output logic        cs,
  output logic        ds,
  output logic        rn_w,
  output logic        bank_addr,
  output logic [3:0]  byte_selects,
  output logic [1:0]  burst_col,
  input  logic        waitstate
);

  localparam logic [31:0] BaseTag = DRAM_BASE >> DRAM_SIZE_LOG2;

  logic as_sync_n, ds_sync_n, cbreq_sync_n;
  logic as_act, cbreq_act, hit, burst_ok, active;

  state_e     state_q, state_d;
  logic       rn_w_q, rn_w_d;
  logic       bank_q, bank_d;
  logic [1:0] siz_q, siz_d;
  logic [1:0] a10_q, a10_d;
  logic       burst_q, burst_d;
  logic [1:0] col_q, col_d;
  logic [1:0] beat_q, beat_d;

  sync2 #(.ResetVal(1'b1)) u_sync_as (
    .clk_i(clock), .rst_i(reset), .d_i(cpu_as_n), .q_o(as_sync_n)
  );
  sync2 #(.ResetVal(1'b1)) u_sync_ds (
    .clk_i(clock), .rst_i(reset), .d_i(cpu_ds_n), .q_o(ds_sync_n)
  );
  sync2 #(.ResetVal(1'b1)) u_sync_cbreq (
    .clk_i(clock), .rst_i(reset), .d_i(cpu_cbreq_n), .q_o(cbreq_sync_n)
  );

  assign as_act    = ~as_sync_n;
  assign cbreq_act = ~cbreq_sync_n;
  assign hit       = (cpu_addr >> DRAM_SIZE_LOG2) == BaseTag;
  assign burst_ok  = cpu_rn_w && (cpu_siz == SizLong) && (cpu_addr[1:0] == 2'b00) && cbreq_act;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      rn_w_q  <= 1'b0;
      bank_q  <= 1'b0;
      siz_q   <= 2'b00;
      a10_q   <= 2'b00;
      burst_q <= 1'b0;
      col_q   <= 2'b00;
      beat_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      rn_w_q  <= rn_w_d;
      bank_q  <= bank_d;
      siz_q   <= siz_d;
      a10_q   <= a10_d;
      burst_q <= burst_d;
      col_q   <= col_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rn_w_d  = rn_w_q;
    bank_d  = bank_q;
    siz_d   = siz_q;
    a10_d   = a10_q;
    burst_d = burst_q;
    col_d   = col_q;
    beat_d  = beat_q;
    case (state_q)
      StIdle: begin
        if (as_act && hit) begin
          state_d = StAccess;
          rn_w_d  = cpu_rn_w;
          bank_d  = cpu_addr[BANK_BIT];
          siz_d   = cpu_siz;
          a10_d   = cpu_addr[1:0];
          burst_d = burst_ok;
          col_d   = cpu_addr[3:2];
          beat_d  = 2'd0;
        end
      end
      StAccess: begin
        // A low waitstate is completion, even on the entry cycle.
        if (!waitstate) begin
          if (!as_act)                                       state_d = StIdle;
          else if (burst_q && cbreq_act && beat_q != 2'd3)   state_d = StBeatGap;
          else                                               state_d = StAck;
        end
      end
      StBeatGap: begin
        state_d = StAccess;
        col_d   = col_q + 2'd1;
        beat_d  = beat_q + 2'd1;
      end
      StAck: begin
        if (!as_act) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    active       = (state_q != StIdle);
    cs           = active;
    ds           = ((state_q == StAccess) || (state_q == StAck)) && (rn_w_q || !ds_sync_n);
    cpu_dsack_n  = ((state_q == StAck) || (state_q == StBeatGap)) ? 2'b00 : 2'b11;
    cpu_cback_n  = ~(active && burst_q);
    rn_w         = active && rn_w_q;
    bank_addr    = active && bank_q;
    byte_selects = active ? lane_mask(siz_q, a10_q) : 4'b0000;
    burst_col    = col_q;
  end

endmodule

// File: tb/tb_simm_bus_interface.sv
// Self-checking bench: the bench plays both 68030 and simm_controller and
// checks each transaction against expectations derived from the bus rules.
module tb_simm_bus_interface;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_as_n, cpu_ds_n, cpu_rn_w, cpu_cbreq_n, waitstate;
  logic [1:0]  cpu_siz;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_dsack_n, burst_col;
  logic        cpu_cback_n, cs, ds, rn_w, bank_addr;
  logic [3:0]  byte_selects;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clock = ~clock;

  simm_bus_interface dut (
    .clock(clock), .reset(reset), .cpu_as_n(cpu_as_n), .cpu_ds_n(cpu_ds_n),
    .cpu_rn_w(cpu_rn_w), .cpu_siz(cpu_siz), .cpu_addr(cpu_addr), .cpu_cbreq_n(cpu_cbreq_n),
    .cpu_dsack_n(cpu_dsack_n), .cpu_cback_n(cpu_cback_n), .cs(cs), .ds(ds), .rn_w(rn_w),
    .bank_addr(bank_addr), .byte_selects(byte_selects), .burst_col(burst_col),
    .waitstate(waitstate)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offsets a .. min(3, a+size-1) as a contiguous run, offset 0 at bit 3.
  function automatic logic [3:0] ref_lanes(input logic [1:0] siz, input logic [1:0] a);
    int size, hi, n;
    size = (siz == 2'b00) ? 4 : int'(siz);
    hi   = int'(a) + size - 1;
    if (hi > 3) hi = 3;
    n = hi - int'(a) + 1;
    return 4'(((1 << n) - 1) << (3 - hi));
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_cs"}, cs, 0);
    check_eq({tag, "_ds"}, ds, 0);
    check_eq({tag, "_dsack"}, cpu_dsack_n, 2'b11);
    check_eq({tag, "_cback"}, cpu_cback_n, 1);
  endtask

  // drop_beat: beat at whose start CBREQ is negated (>=4 means never).
  task automatic do_xfer(input logic [31:0] addr, input logic [1:0] siz, input bit rnw,
                         input bit cbreq, input int delay, input int drop_beat, input bit abort);
    bit         hit, burst;
    int         beats, d;
    logic [1:0] col;
    hit   = (addr >> 26) == 0;
    burst = hit && rnw && siz == 2'b00 && addr[1:0] == 2'b00 && cbreq;
    beats = burst ? ((drop_beat < 3) ? drop_beat + 1 : 4) : 1;
    d     = (delay < 3) ? 3 : delay;
    cpu_addr = addr; cpu_siz = siz; cpu_rn_w = rnw; cpu_cbreq_n = !cbreq; waitstate = 1'b1;
    cpu_as_n = 1'b0; cpu_ds_n = !rnw;
    if (!hit) begin
      for (int i = 0; i < 6; i++) begin
        tick();
        check_eq("miss_cs", cs, 0);
        check_eq("miss_dsack", cpu_dsack_n, 2'b11);
      end
    end else begin
      tick(); check_eq("cs_edge1", cs, 0);
      tick(); check_eq("cs_edge2", cs, 0);
      tick(); check_eq("cs_edge3", cs, 1);
      check_eq("lanes", byte_selects, ref_lanes(siz, addr[1:0]));
      check_eq("rn_w", rn_w, rnw);
      check_eq("bank", bank_addr, addr[25]);
      check_eq("cback", cpu_cback_n, !burst);
      check_eq("ds_entry", ds, rnw);
      if (!rnw) cpu_ds_n = 1'b0;
      if (abort) begin
        cpu_as_n = 1'b1; cpu_ds_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          tick();
          check_eq("abort_cs_hold", cs, 1);
          check_eq("abort_dsack", cpu_dsack_n, 2'b11);
        end
        waitstate = 1'b0; tick(); waitstate = 1'b1;
        check_eq("abort_cs_drop", cs, 0);
        check_eq("abort_dsack_end", cpu_dsack_n, 2'b11);
      end else begin
        for (int b = 0; b < beats; b++) begin
          col = addr[3:2] + 2'(b);
          check_eq("burst_col", burst_col, col);
          if (b == drop_beat) cpu_cbreq_n = 1'b1;
          for (int i = 1; i < d; i++) begin
            tick();
            check_eq("wait_cs", cs, 1);
            check_eq("wait_dsack", cpu_dsack_n, 2'b11);
            if (b == 0 && !rnw) check_eq("wr_ds_follow", ds, (i >= 2));
          end
          waitstate = 1'b0; tick(); waitstate = 1'b1;
          check_eq("dsack_beat", cpu_dsack_n, 2'b00);
          if (b < beats - 1) begin
            check_eq("gap_ds", ds, 0);
            tick();
            check_eq("gap_pulse_end", cpu_dsack_n, 2'b11);
            check_eq("gap_ds_back", ds, 1);
          end
        end
        cpu_as_n = 1'b1; cpu_ds_n = 1'b1; cpu_cbreq_n = 1'b1;
        tick(); check_eq("ack_hold1", cpu_dsack_n, 2'b00);
        tick(); check_eq("ack_hold2", cpu_dsack_n, 2'b00);
        tick(); check_idle("ack_release");
      end
    end
    cpu_as_n = 1'b1; cpu_ds_n = 1'b1; cpu_cbreq_n = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    reset = 1'b1; cpu_as_n = 1'b1; cpu_ds_n = 1'b1; cpu_rn_w = 1'b1; cpu_cbreq_n = 1'b1;
    cpu_siz = 2'b00; cpu_addr = '0; waitstate = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check_idle("reset");
    check_eq("reset_lanes", byte_selects, 4'b0000);
    check_eq("reset_col", burst_col, 2'b00);
    check_eq("reset_rn_w", rn_w, 0);
    tick();

    do_xfer(32'h0000_0100, 2'b00, 1, 0, 6, 4, 0);  // long read
    do_xfer(32'h0200_0003, 2'b01, 0, 0, 4, 4, 0);  // byte write, bank 1
    do_xfer(32'h0000_0008, 2'b00, 1, 1, 3, 4, 0);  // burst fill, cols 10,11,00,01
    do_xfer(32'h0400_0000, 2'b00, 1, 0, 3, 4, 0);  // miss
    do_xfer(32'h0000_0100, 2'b10, 1, 1, 3, 4, 0);  // CBREQ with SIZ=10
    do_xfer(32'h0000_0200, 2'b00, 1, 0, 3, 4, 1);  // AS abort
    do_xfer(32'h0000_000c, 2'b00, 1, 1, 4, 1, 0);  // CBREQ negated at beat 1

    // Reset in the middle of an access.
    cpu_addr = 32'h0000_0100; cpu_siz = 2'b00; cpu_rn_w = 1'b1; cpu_as_n = 1'b0; cpu_ds_n = 1'b0;
    cpu_cbreq_n = 1'b0;
    tick(); tick(); tick();
    check_eq("pre_reset_cs", cs, 1);
    reset = 1'b1;
    tick();
    check_idle("mid_reset");
    check_eq("mid_reset_lanes", byte_selects, 4'b0000);
    check_eq("mid_reset_col", burst_col, 2'b00);
    reset = 1'b0; cpu_as_n = 1'b1; cpu_ds_n = 1'b1; cpu_cbreq_n = 1'b1;
    tick(); tick(); tick();

    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 4; a++) begin
        do_xfer(32'h0000_0100 | 32'(a), 2'(s), 0, 0, 3, 4, 0);
      end
    end

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ad;
      logic [1:0]  sz;
      bit          rw, cb, ab;
      ad = $urandom & 32'h03ff_ffff;
      if ($urandom_range(0, 4) == 0) ad[31:26] = 6'($urandom_range(1, 63));
      sz = 2'($urandom);
      rw = 1'($urandom_range(0, 1));
      cb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        sz = 2'b00; ad[1:0] = 2'b00; rw = 1'b1; cb = 1'b1;
      end
      ab = ($urandom_range(0, 7) == 0);
      do_xfer(ad, sz, rw, cb, int'($urandom_range(3, 6)), int'($urandom_range(0, 6)), ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
